cw_run_sequencer: RTL and testbench
===================================

Name: cw_run_sequencer

Overview:
- Controls codeword-detection test runs. It loads a seed into the LFSR, then runs the LFSR-plus-detector pair for a programmable window of cycles.
- It counts detector hits per window and reports each window's count over a valid/ready handshake.
- It repeats for a programmable number of runs and accumulates a total.
- It sits between the top-level control/UART logic and the LFSR and codeword-detector FSM.

Parameters:
- LFSR_W, 11, width of LFSR seed.
- WIN_W, 16, width of window-length counter.
- CNT_W, 11, width of per-run hit count (matches detector counter).
- RUN_W, 8, width of run-count and run-index fields.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request to begin a sequence; sampled only in IDLE.
- abort  in  1  terminate the current sequence; no result, no done.
- seed  in  LFSR_W  seed, captured at start.
- win_len  in  WIN_W  window length in cycles, captured at start.
- num_runs  in  RUN_W  number of windows, captured at start.
- cw_detected  in  1  detector hit flag, high one cycle per codeword.
- lfsr_load  out  1  load lfsr_seed into LFSR this cycle.
- lfsr_seed  out  LFSR_W  captured seed.
- lfsr_en  out  1  LFSR advance enable.
- det_rst_n  out  1  synchronous active-low reset to the detector.
- max_tick  out  1  window-end pulse to the detector (clears its counter).
- busy  out  1  high in any state other than IDLE.
- res_valid  out  1  per-run result valid.
- res_ready  in  1  consumer accepts result.
- res_count  out  CNT_W  hits in the reported window.
- res_index  out  RUN_W  0-based run number of the reported result.
- res_sat  out  1  res_count saturated.
- done  out  1  one-cycle pulse at end of a full sequence.
- total  out  CNT_W+RUN_W  sum of all run counts; valid while done is high, held until next start.

Behaviour:
- Reset (rst_n=0 at a clock edge), next state IDLE:
  - outputs 0: lfsr_load, lfsr_en, max_tick, busy, res_valid, done, res_sat.
  - det_rst_n=0.
  - res_count, res_index, total, lfsr_seed all 0.
  - Reset mid-operation behaves identically; no result and no done.
- States: IDLE, LOAD, RUN, REPORT.
- IDLE:
  - det_rst_n=0.
  - On start with num_runs!=0: capture seed, win_len, num_runs; clear total and run index; go to LOAD.
  - On start with num_runs==0: done=1 the next cycle, total=0, stay IDLE.
  - start outside IDLE is ignored.
- LOAD (1 cycle): lfsr_load=1, det_rst_n=0, lfsr_en=0. Go to RUN.
- RUN:
  - lfsr_en=1, det_rst_n=1.
  - Window counter runs 0..L-1, where L=win_len, and win_len==0 is treated as L=1.
  - cw_detected is counted on every RUN cycle, including the last; the count saturates at 2^CNT_W-1 and sets the sat flag.
  - max_tick=1 only on the cycle where the window counter equals L-1.
  - The next cycle goes to REPORT, with res_count, res_sat and res_index registered.
- REPORT:
  - res_valid=1; res_* held stable while res_ready=0.
  - lfsr_en=0 (LFSR state frozen), det_rst_n=0 (detector enters next window from IDLE).
  - Hits spanning windows are not counted.
  - On res_valid&res_ready: total += res_count.
    - If more runs remain: run index+1, go to RUN. There is no LFSR reload; the LFSR continues its sequence.
    - Otherwise go to IDLE with done=1 for one cycle, showing the updated total.
- lfsr_load asserts exactly once per sequence.
- abort has priority over everything except rst_n:
  - next state IDLE, res_valid=0, no done.
  - total holds its partial value but is not flagged.
- abort and start together in IDLE: abort wins; no sequence starts.
- total width CNT_W+RUN_W cannot overflow.

Test Plan:
- Reset: hold rst_n=0 3 cycles with start=1 -> all outputs at reset values, det_rst_n=0, busy=0.
- Single run: num_runs=1, win_len=8, seed=11'h5A5; cw_detected pulses on RUN cycles 3 and 8 -> expected response:
  - lfsr_load one cycle after start.
  - lfsr_en high for 8 cycles, max_tick on 8th.
  - res_valid with res_count=2, res_index=0.
  - After ready: done pulse with total=2.
- Backpressure: num_runs=3, win_len=4, 1 hit per window, res_ready low for 5 cycles on run 1 -> expected response:
  - res_count/res_index stable and lfsr_en=0 during the stall.
  - res_index sequence 0,1,2; lfsr_load asserted once; total=3.
- Boundaries:
  - win_len=0 -> exactly one RUN cycle, with max_tick on it.
  - num_runs=0 -> done one cycle after start, total=0, no res_valid, no lfsr_load.
- Saturation: CNT_W=4, win_len=20, cw_detected held high -> res_count=15, res_sat=1.
- Abort and reset: abort on RUN cycle 3 of 8 -> IDLE next cycle, busy=0, no res_valid, no done; repeat with rst_n=0 instead -> same result plus outputs at reset values.

Source files
------------

// File: rtl/cw_run_sequencer.sv
// Codeword-detection run sequencer: seeds the LFSR once, then runs N windows of
// L cycles, reporting per-window detector hit counts and a running total.
module cw_run_sequencer #(
    parameter int unsigned LFSR_W = 11,
    parameter int unsigned WIN_W  = 16,
    parameter int unsigned CNT_W  = 11,
    parameter int unsigned RUN_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic [LFSR_W-1:0]        seed,
    input  logic [WIN_W-1:0]         win_len,
    input  logic [RUN_W-1:0]         num_runs,
    input  logic                     cw_detected,
    output logic                     lfsr_load,
    output logic [LFSR_W-1:0]        lfsr_seed,
    output logic                     lfsr_en,
    output logic                     det_rst_n,
    output logic                     max_tick,
    output logic                     busy,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [CNT_W-1:0]         res_count,
    output logic [RUN_W-1:0]         res_index,
    output logic                     res_sat,
    output logic                     done,
    output logic [CNT_W+RUN_W-1:0]   total
);

    localparam int unsigned TOT_W = CNT_W + RUN_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        RUN    = 2'd2,
        REPORT = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [WIN_W-1:0]  win_cnt, win_cnt_nxt;
    logic [WIN_W-1:0]  win_last, win_last_nxt;
    logic [RUN_W-1:0]  runs_last, runs_last_nxt;
    logic [RUN_W-1:0]  run_idx, run_idx_nxt;
    logic [CNT_W-1:0]  hit_cnt, hit_nxt;
    logic              hit_sat, sat_nxt;
    logic [LFSR_W-1:0] seed_nxt;
    logic [TOT_W-1:0]  total_nxt;
    logic [CNT_W-1:0]  res_count_nxt;
    logic              res_sat_nxt;
    logic [RUN_W-1:0]  res_index_nxt;
    logic              done_nxt;

    // Next-state and datapath update; abort overrides every state.
    always_comb begin
        state_nxt     = state;
        win_cnt_nxt   = win_cnt;
        win_last_nxt  = win_last;
        runs_last_nxt = runs_last;
        run_idx_nxt   = run_idx;
        hit_nxt       = hit_cnt;
        sat_nxt       = hit_sat;
        seed_nxt      = lfsr_seed;
        total_nxt     = total;
        res_count_nxt = res_count;
        res_sat_nxt   = res_sat;
        res_index_nxt = res_index;
        done_nxt      = 1'b0;

        if (abort) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        total_nxt = '0;
                        if (num_runs != '0) begin
                            seed_nxt      = seed;
                            win_last_nxt  = (win_len == '0) ? '0 : win_len - WIN_W'(1);
                            runs_last_nxt = num_runs - RUN_W'(1);
                            run_idx_nxt   = '0;
                            state_nxt     = LOAD;
                        end else begin
                            done_nxt = 1'b1;
                        end
                    end
                end
                LOAD: begin
                    win_cnt_nxt = '0;
                    hit_nxt     = '0;
                    sat_nxt     = 1'b0;
                    state_nxt   = RUN;
                end
                RUN: begin
                    if (cw_detected) begin
                        if (hit_cnt == CNT_MAX) begin
                            sat_nxt = 1'b1;
                        end else begin
                            hit_nxt = hit_cnt + CNT_W'(1);
                        end
                    end
                    // Last window cycle still counts its hit before the result is latched.
                    if (win_cnt == win_last) begin
                        res_count_nxt = hit_nxt;
                        res_sat_nxt   = sat_nxt;
                        res_index_nxt = run_idx;
                        state_nxt     = REPORT;
                    end else begin
                        win_cnt_nxt = win_cnt + WIN_W'(1);
                    end
                end
                REPORT: begin
                    if (res_ready) begin
                        total_nxt = total + TOT_W'(res_count);
                        if (run_idx == runs_last) begin
                            done_nxt  = 1'b1;
                            state_nxt = IDLE;
                        end else begin
                            run_idx_nxt = run_idx + RUN_W'(1);
                            win_cnt_nxt = '0;
                            hit_nxt     = '0;
                            sat_nxt     = 1'b0;
                            state_nxt   = RUN;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State, datapath and registered outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            win_cnt   <= '0;
            win_last  <= '0;
            runs_last <= '0;
            run_idx   <= '0;
            hit_cnt   <= '0;
            hit_sat   <= 1'b0;
            lfsr_seed <= '0;
            total     <= '0;
            res_count <= '0;
            res_sat   <= 1'b0;
            res_index <= '0;
            done      <= 1'b0;
            lfsr_load <= 1'b0;
            lfsr_en   <= 1'b0;
            det_rst_n <= 1'b0;
            max_tick  <= 1'b0;
            busy      <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            win_cnt   <= win_cnt_nxt;
            win_last  <= win_last_nxt;
            runs_last <= runs_last_nxt;
            run_idx   <= run_idx_nxt;
            hit_cnt   <= hit_nxt;
            hit_sat   <= sat_nxt;
            lfsr_seed <= seed_nxt;
            total     <= total_nxt;
            res_count <= res_count_nxt;
            res_sat   <= res_sat_nxt;
            res_index <= res_index_nxt;
            done      <= done_nxt;
            lfsr_load <= (state_nxt == LOAD);
            lfsr_en   <= (state_nxt == RUN);
            det_rst_n <= (state_nxt == RUN);
            max_tick  <= (state_nxt == RUN) && (win_cnt_nxt == win_last_nxt);
            busy      <= (state_nxt != IDLE);
            res_valid <= (state_nxt == REPORT);
        end
    end

endmodule

// File: tb/tb_cw_run_sequencer.sv
// Self-checking bench for cw_run_sequencer: table vectors, randomized sequences
// against a window-level hit model, plus abort/reset corner sequences.
module tb_cw_run_sequencer;

    localparam int unsigned LFSR_W = 11;
    localparam int unsigned WIN_W  = 16;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned RUN_W  = 8;
    localparam int unsigned TOT_W  = CNT_W + RUN_W;
    localparam int          CMAX   = (1 << CNT_W) - 1;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              abort;
    logic [LFSR_W-1:0] seed;
    logic [WIN_W-1:0]  win_len;
    logic [RUN_W-1:0]  num_runs;
    logic              cw_detected;
    logic              lfsr_load;
    logic [LFSR_W-1:0] lfsr_seed;
    logic              lfsr_en;
    logic              det_rst_n;
    logic              max_tick;
    logic              busy;
    logic              res_valid;
    logic              res_ready;
    logic [CNT_W-1:0]  res_count;
    logic [RUN_W-1:0]  res_index;
    logic              res_sat;
    logic              done;
    logic [TOT_W-1:0]  total;

    cw_run_sequencer #(
        .LFSR_W(LFSR_W), .WIN_W(WIN_W), .CNT_W(CNT_W), .RUN_W(RUN_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .seed(seed), .win_len(win_len), .num_runs(num_runs),
        .cw_detected(cw_detected), .lfsr_load(lfsr_load), .lfsr_seed(lfsr_seed),
        .lfsr_en(lfsr_en), .det_rst_n(det_rst_n), .max_tick(max_tick),
        .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
        .res_count(res_count), .res_index(res_index), .res_sat(res_sat),
        .done(done), .total(total)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int nr;
        int wl;
        int sd;
        int mode;       // 0 none, 1 all ones, 2 hits on cycles 3 and L, 3 hit on cycle 1, 4 random
        int stall_idx;
        int stall_len;
        int exp_total;  // -1: use model total
    } vec_t;

    vec_t vecs[8];
    int   n_checks;
    int   n_fail;
    int   last_total;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_seq(input vec_t v);
        int   len, hits, tot, loads, exp_cnt, stall;
        logic exp_sat;
        len = (v.wl == 0) ? 1 : v.wl;
        tot = 0;
        seed = LFSR_W'(v.sd);
        win_len = WIN_W'(v.wl);
        num_runs = RUN_W'(v.nr);
        start = 1'b1;
        res_ready = 1'b0;
        cw_detected = 1'b0;
        tick();
        start = 1'b0;
        seed = LFSR_W'($urandom);
        win_len = WIN_W'($urandom);
        num_runs = RUN_W'($urandom);
        if (v.nr == 0) begin
            check("zero_done", done, 1);
            check("zero_total", total, 0);
            check("zero_load", lfsr_load, 0);
            check("zero_valid", res_valid, 0);
            check("zero_busy", busy, 0);
            tick();
            check("zero_done_pulse", done, 0);
            last_total = 0;
            return;
        end
        check("load_pulse", lfsr_load, 1);
        check("load_en", lfsr_en, 0);
        check("load_det", det_rst_n, 0);
        check("load_seed", lfsr_seed, v.sd);
        check("load_busy", busy, 1);
        loads = int'(lfsr_load);
        cw_detected = 1'($urandom);
        for (int r = 0; r < v.nr; r++) begin
            hits = 0;
            for (int k = 1; k <= len; k++) begin
                tick();
                loads += int'(lfsr_load);
                check("run_en", lfsr_en, 1);
                check("run_det", det_rst_n, 1);
                check("run_tick", max_tick, (k == len));
                check("run_valid", res_valid, 0);
                case (v.mode)
                    0: cw_detected = 1'b0;
                    1: cw_detected = 1'b1;
                    2: cw_detected = (k == 3) || (k == len);
                    3: cw_detected = (k == 1);
                    default: cw_detected = 1'($urandom);
                endcase
                if (v.mode == 4) start = ($urandom_range(0, 3) == 0);
                hits += int'(cw_detected);
            end
            tick();
            start = 1'b0;
            loads += int'(lfsr_load);
            exp_cnt = (hits > CMAX) ? CMAX : hits;
            exp_sat = (hits > CMAX);
            check("rep_valid", res_valid, 1);
            check("rep_count", res_count, exp_cnt);
            check("rep_sat", res_sat, exp_sat);
            check("rep_index", res_index, r);
            check("rep_en", lfsr_en, 0);
            check("rep_det", det_rst_n, 0);
            check("rep_seed", lfsr_seed, v.sd);
            stall = (r == v.stall_idx) ? v.stall_len
                                       : ((v.mode == 4) ? int'($urandom_range(0, 2)) : 0);
            for (int s = 0; s < stall; s++) begin
                res_ready = 1'b0;
                cw_detected = 1'($urandom);
                tick();
                loads += int'(lfsr_load);
                check("stall_valid", res_valid, 1);
                check("stall_count", res_count, exp_cnt);
                check("stall_index", res_index, r);
                check("stall_en", lfsr_en, 0);
            end
            res_ready = 1'b1;
            cw_detected = 1'($urandom);
            tot += exp_cnt;
        end
        tick();
        res_ready = 1'b0;
        cw_detected = 1'b0;
        loads += int'(lfsr_load);
        check("end_done", done, 1);
        check("end_total", total, (v.exp_total >= 0) ? v.exp_total : tot);
        check("end_busy", busy, 0);
        check("end_valid", res_valid, 0);
        check("load_once", loads, 1);
        last_total = tot;
        tick();
        check("done_pulse", done, 0);
        check("total_hold", total, tot);
    endtask

    task automatic abort_test(input bit use_rst);
        int bad;
        seed = 11'h3C7;
        win_len = 16'd8;
        num_runs = 8'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            cw_detected = 1'b1;
        end
        if (use_rst) rst_n = 1'b0;
        else abort = 1'b1;
        tick();
        rst_n = 1'b1;
        abort = 1'b0;
        cw_detected = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_valid", res_valid, 0);
        check("abort_done", done, 0);
        check("abort_en", lfsr_en, 0);
        check("abort_det", det_rst_n, 0);
        check("abort_tick", max_tick, 0);
        if (use_rst) begin
            check("rst_count", res_count, 0);
            check("rst_index", res_index, 0);
            check("rst_total", total, 0);
            check("rst_seed", lfsr_seed, 0);
            check("rst_sat", res_sat, 0);
        end
        bad = 0;
        repeat (8) begin
            tick();
            if (done || res_valid || busy || lfsr_en) bad++;
        end
        check("abort_quiet", bad, 0);
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        last_total = 0;
        rst_n = 1'b0;
        start = 1'b1;
        abort = 1'b0;
        seed = 11'h7FF;
        win_len = 16'd5;
        num_runs = 8'd3;
        cw_detected = 1'b1;
        res_ready = 1'b1;

        vecs[0] = '{nr: 1, wl: 8,  sd: 'h5A5, mode: 2, stall_idx: -1, stall_len: 0, exp_total: 2};
        vecs[1] = '{nr: 3, wl: 4,  sd: 'h123, mode: 3, stall_idx: 1,  stall_len: 5, exp_total: 3};
        vecs[2] = '{nr: 1, wl: 0,  sd: 'h001, mode: 1, stall_idx: -1, stall_len: 0, exp_total: 1};
        vecs[3] = '{nr: 0, wl: 6,  sd: 'h222, mode: 1, stall_idx: -1, stall_len: 0, exp_total: 0};
        vecs[4] = '{nr: 1, wl: 20, sd: 'h444, mode: 1, stall_idx: 0,  stall_len: 2, exp_total: 15};
        vecs[5] = '{nr: 2, wl: 1,  sd: 'h0F0, mode: 1, stall_idx: -1, stall_len: 0, exp_total: 2};
        vecs[6] = '{nr: 4, wl: 30, sd: 'h6B1, mode: 4, stall_idx: 2,  stall_len: 2, exp_total: -1};
        vecs[7] = '{nr: 5, wl: 17, sd: 'h3D2, mode: 4, stall_idx: 0,  stall_len: 3, exp_total: -1};

        @(negedge clk);
        repeat (3) tick();
        check("rst_lfsr_load", lfsr_load, 0);
        check("rst_lfsr_en", lfsr_en, 0);
        check("rst_max_tick", max_tick, 0);
        check("rst_busy", busy, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_done", done, 0);
        check("rst_res_sat", res_sat, 0);
        check("rst_det_rst_n", det_rst_n, 0);
        check("rst_res_count", res_count, 0);
        check("rst_res_index", res_index, 0);
        check("rst_total", total, 0);
        check("rst_lfsr_seed", lfsr_seed, 0);
        rst_n = 1'b1;
        start = 1'b0;
        cw_detected = 1'b0;
        res_ready = 1'b0;
        tick();
        check("idle_busy", busy, 0);

        for (int i = 0; i < 8; i++) run_seq(vecs[i]);

        // Start and abort together in IDLE: nothing starts, total untouched.
        start = 1'b1;
        abort = 1'b1;
        num_runs = 8'd1;
        win_len = 16'd3;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("sa_busy", busy, 0);
        check("sa_load", lfsr_load, 0);
        check("sa_total", total, last_total);
        tick();
        check("sa_busy2", busy, 0);

        for (int i = 0; i < 6; i++) begin
            vec_t v;
            v.nr = int'($urandom_range(1, 4));
            v.wl = int'($urandom_range(0, 24));
            v.sd = int'($urandom_range(0, 2047));
            v.mode = 4;
            v.stall_idx = int'($urandom_range(0, 3));
            v.stall_len = int'($urandom_range(1, 6));
            v.exp_total = -1;
            run_seq(v);
        end

        abort_test(1'b0);
        abort_test(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
